// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: memory-side stage behind the SPI slave. It decodes word
// accesses into control/status registers, a weight FIFO (SPI -> CNN) and a
// result FIFO (CNN -> SPI).
module spi_mem_bridge #(
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned WT_DEPTH  = 16,
    parameter int unsigned RES_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_en,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DWIDTH-1:0] addr_mem,
    input  logic [DWIDTH-1:0] wr_data_mem,
    output logic [DWIDTH-1:0] rd_data_mem,
    output logic [DWIDTH-1:0] wt_data,
    output logic              wt_valid,
    input  logic              wt_ready,
    input  logic [DWIDTH-1:0] res_data,
    input  logic              res_valid,
    output logic              res_ready,
    output logic              cnn_start,
    input  logic              cnn_busy,
    input  logic              cnn_done
);

    localparam int unsigned AW     = DWIDTH - 1;
    localparam int unsigned WT_PW  = $clog2(WT_DEPTH);
    localparam int unsigned WT_CW  = WT_PW + 1;
    localparam int unsigned RES_PW = $clog2(RES_DEPTH);
    localparam int unsigned RES_CW = RES_PW + 1;

    localparam logic [AW-1:0] A_CTRL    = AW'(16'h000);
    localparam logic [AW-1:0] A_STATUS  = AW'(16'h001);
    localparam logic [AW-1:0] A_WT_CNT  = AW'(16'h002);
    localparam logic [AW-1:0] A_RES_CNT = AW'(16'h003);
    localparam logic [AW-1:0] A_SCRATCH = AW'(16'h004);
    localparam logic [AW-1:0] A_RES_LO  = AW'(16'h100);
    localparam logic [AW-1:0] A_RES_HI  = AW'(16'h1FF);
    localparam logic [AW-1:0] A_WT_LO   = AW'(16'h200);
    localparam logic [AW-1:0] A_WT_HI   = AW'(16'h2FF);

    // Top address bit is the SPI W/R flag and carries no decode information
    logic unused_addr_flag;
    assign unused_addr_flag = addr_mem[DWIDTH-1];

    logic [AW-1:0] addr_dec;
    logic          wr_acc, rd_acc;
    logic          res_win, wt_win;
    logic          ctrl_wr, flush, clr_flags;

    assign addr_dec  = addr_mem[AW-1:0];
    assign wr_acc    = mem_en && wr_en;
    assign rd_acc    = mem_en && rd_en;
    assign res_win   = (addr_dec >= A_RES_LO) && (addr_dec <= A_RES_HI);
    assign wt_win    = (addr_dec >= A_WT_LO) && (addr_dec <= A_WT_HI);
    assign ctrl_wr   = wr_acc && (addr_dec == A_CTRL);
    assign flush     = ctrl_wr && wr_data_mem[2];
    assign clr_flags = ctrl_wr && wr_data_mem[1];

    // Weight FIFO state
    logic [DWIDTH-1:0] wt_mem [WT_DEPTH];
    logic [WT_PW-1:0]  wt_wr_ptr, wt_rd_ptr;
    logic [WT_CW-1:0]  wt_cnt;
    logic              wt_full, wt_empty, wt_push_req, wt_push, wt_pop;

    assign wt_full     = (wt_cnt == WT_CW'(WT_DEPTH));
    assign wt_empty    = (wt_cnt == '0);
    assign wt_valid    = !wt_empty;
    assign wt_push_req = wr_acc && wt_win;
    assign wt_push     = wt_push_req && !wt_full;
    assign wt_pop      = wt_valid && wt_ready;
    assign wt_data     = wt_valid ? wt_mem[wt_rd_ptr] : '0;

    // Result FIFO state
    logic [DWIDTH-1:0] res_mem [RES_DEPTH];
    logic [RES_PW-1:0] res_wr_ptr, res_rd_ptr;
    logic [RES_CW-1:0] res_cnt;
    logic              res_full, res_empty, res_rd, res_push, res_pop;

    assign res_full  = (res_cnt == RES_CW'(RES_DEPTH));
    assign res_empty = (res_cnt == '0);
    assign res_ready = !res_full;
    assign res_rd    = rd_acc && res_win;
    assign res_push  = res_valid && res_ready;
    assign res_pop   = res_rd && !res_empty;

    // Weight FIFO storage (pointers decide what is live, so no reset needed)
    always_ff @(posedge clk) begin
        if (wt_push) begin
            wt_mem[wt_wr_ptr] <= wr_data_mem;
        end
    end

    // Weight FIFO pointers and occupancy; flush overrides push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_wr_ptr <= '0;
            wt_rd_ptr <= '0;
            wt_cnt    <= '0;
        end else if (flush) begin
            wt_wr_ptr <= '0;
            wt_rd_ptr <= '0;
            wt_cnt    <= '0;
        end else begin
            if (wt_push) begin
                wt_wr_ptr <= wt_wr_ptr + WT_PW'(1);
            end
            if (wt_pop) begin
                wt_rd_ptr <= wt_rd_ptr + WT_PW'(1);
            end
            case ({wt_push, wt_pop})
                2'b10:   wt_cnt <= wt_cnt + WT_CW'(1);
                2'b01:   wt_cnt <= wt_cnt - WT_CW'(1);
                default: wt_cnt <= wt_cnt;
            endcase
        end
    end

    // Result FIFO storage
    always_ff @(posedge clk) begin
        if (res_push) begin
            res_mem[res_wr_ptr] <= res_data;
        end
    end

    // Result FIFO pointers and occupancy; flush overrides push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_cnt    <= '0;
        end else if (flush) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_cnt    <= '0;
        end else begin
            if (res_push) begin
                res_wr_ptr <= res_wr_ptr + RES_PW'(1);
            end
            if (res_pop) begin
                res_rd_ptr <= res_rd_ptr + RES_PW'(1);
            end
            case ({res_push, res_pop})
                2'b10:   res_cnt <= res_cnt + RES_CW'(1);
                2'b01:   res_cnt <= res_cnt - RES_CW'(1);
                default: res_cnt <= res_cnt;
            endcase
        end
    end

    // Control registers, sticky flags and the start pulse
    logic [DWIDTH-1:0] scratch;
    logic              done_sticky, wt_ovf, res_unf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch     <= '0;
            done_sticky <= 1'b0;
            wt_ovf      <= 1'b0;
            res_unf     <= 1'b0;
            cnn_start   <= 1'b0;
        end else begin
            cnn_start <= ctrl_wr && wr_data_mem[0] && !cnn_busy;
            if (wr_acc && (addr_dec == A_SCRATCH)) begin
                scratch <= wr_data_mem;
            end
            if (cnn_done) begin
                done_sticky <= 1'b1;
            end else if (clr_flags) begin
                done_sticky <= 1'b0;
            end
            if (wt_push_req && wt_full) begin
                wt_ovf <= 1'b1;
            end else if (clr_flags) begin
                wt_ovf <= 1'b0;
            end
            if (res_rd && res_empty) begin
                res_unf <= 1'b1;
            end else if (clr_flags) begin
                res_unf <= 1'b0;
            end
        end
    end

    // Combinational read decode; the SPI top samples it on the access edge
    always_comb begin
        rd_data_mem = '0;
        if (rd_acc && rst_n) begin
            if (addr_dec == A_STATUS) begin
                rd_data_mem = DWIDTH'({res_unf, wt_ovf, res_empty, wt_empty,
                                       wt_full, done_sticky, cnn_busy});
            end else if (addr_dec == A_WT_CNT) begin
                rd_data_mem = DWIDTH'(wt_cnt);
            end else if (addr_dec == A_RES_CNT) begin
                rd_data_mem = DWIDTH'(res_cnt);
            end else if (addr_dec == A_SCRATCH) begin
                rd_data_mem = scratch;
            end else if (res_win && !res_empty) begin
                rd_data_mem = res_mem[res_rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: scoreboard bench for spi_mem_bridge with a queue-based
// reference model, directed scenarios and a randomized traffic phase.
`timescale 1ns/1ps
module tb_spi_mem_bridge;

    localparam int WD = 16;
    localparam int RD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] addr_mem = '0, wr_data_mem = '0;
    logic [15:0] rd_data_mem, wt_data, res_data = '0;
    logic        wt_valid, wt_ready = 1'b0, res_valid = 1'b0, res_ready;
    logic        cnn_start, cnn_busy = 1'b0, cnn_done = 1'b0;

    spi_mem_bridge #(.DWIDTH(16), .WT_DEPTH(WD), .RES_DEPTH(RD)) dut (
        .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .wr_en(wr_en), .rd_en(rd_en),
        .addr_mem(addr_mem), .wr_data_mem(wr_data_mem), .rd_data_mem(rd_data_mem),
        .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .cnn_start(cnn_start), .cnn_busy(cnn_busy), .cnn_done(cnn_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: plain queues and flags updated once per clock edge
    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp;
    } rd_exp_t;

    logic [15:0] m_wt_q[$];
    logic [15:0] m_res_q[$];
    logic [15:0] wt_exp_q[$];
    rd_exp_t     rd_exp_q[$];
    logic [15:0] m_scratch = '0;
    logic        m_done = 1'b0, m_ovf = 1'b0, m_unf = 1'b0, m_start = 1'b0;

    logic [14:0] md_a;
    logic        md_wr, md_rd, md_ctrl, md_flush, md_clr, md_wtw, md_resw;
    int          md_wsz, md_rsz;

    function automatic bit in_wt_win(input logic [14:0] a);
        return (a >= 15'h200) && (a <= 15'h2FF);
    endfunction

    function automatic bit in_res_win(input logic [14:0] a);
        return (a >= 15'h100) && (a <= 15'h1FF);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wt_q.delete();
            m_res_q.delete();
            wt_exp_q.delete();
            m_scratch = '0;
            m_done = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_start = 1'b0;
        end else begin
            md_wr    = mem_en && wr_en;
            md_rd    = mem_en && rd_en;
            md_a     = addr_mem[14:0];
            md_wsz   = m_wt_q.size();
            md_rsz   = m_res_q.size();
            md_wtw   = md_wr && in_wt_win(md_a);
            md_resw  = md_rd && in_res_win(md_a);
            md_ctrl  = md_wr && (md_a == 15'h000);
            md_flush = md_ctrl && wr_data_mem[2];
            md_clr   = md_ctrl && wr_data_mem[1];
            m_start  = md_ctrl && wr_data_mem[0] && !cnn_busy;
            if (cnn_done) m_done = 1'b1;
            else if (md_clr) m_done = 1'b0;
            if (md_wtw && md_wsz == WD) m_ovf = 1'b1;
            else if (md_clr) m_ovf = 1'b0;
            if (md_resw && md_rsz == 0) m_unf = 1'b1;
            else if (md_clr) m_unf = 1'b0;
            if (md_wr && md_a == 15'h004) m_scratch = wr_data_mem;
            if (md_flush) begin
                m_wt_q.delete();
                m_res_q.delete();
                wt_exp_q.delete();
            end else begin
                if (md_wsz > 0 && wt_ready) void'(m_wt_q.pop_front());
                if (md_wtw && md_wsz < WD) m_wt_q.push_back(wr_data_mem);
                if (md_resw && md_rsz > 0) void'(m_res_q.pop_front());
                if (res_valid && md_rsz < RD) m_res_q.push_back(res_data);
            end
        end
    end

    function automatic logic [15:0] model_read(input logic [15:0] addr);
        logic [14:0] a;
        a = addr[14:0];
        if (a == 15'h001)
            return {9'd0, m_unf, m_ovf, (m_res_q.size() == 0), (m_wt_q.size() == 0),
                    (m_wt_q.size() == WD), m_done, cnn_busy};
        if (a == 15'h002) return 16'(m_wt_q.size());
        if (a == 15'h003) return 16'(m_res_q.size());
        if (a == 15'h004) return m_scratch;
        if (in_res_win(a)) return (m_res_q.size() > 0) ? m_res_q[0] : 16'h0000;
        return 16'h0000;
    endfunction

    // One SPI word access; expectations are queued before the access edge
    task automatic acc(input bit w, input bit r, input logic [15:0] addr,
                       input logic [15:0] data, input bit use_exp, input logic [15:0] exp);
        rd_exp_t e;
        if (r) begin
            e.addr = addr;
            e.exp  = use_exp ? exp : model_read(addr);
            rd_exp_q.push_back(e);
        end
        if (w && in_wt_win(addr[14:0]) && m_wt_q.size() < WD) wt_exp_q.push_back(data);
        mem_en      = w || r;
        wr_en       = w;
        rd_en       = r;
        addr_mem    = addr;
        wr_data_mem = data;
        @(posedge clk);
        #1;
        mem_en = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        acc(1'b1, 1'b0, addr, data, 1'b0, 16'h0);
    endtask

    task automatic rd_const(input logic [15:0] addr, input logic [15:0] exp);
        acc(1'b0, 1'b1, addr, 16'h0, 1'b1, exp);
    endtask

    task automatic rd_mdl(input logic [15:0] addr);
        acc(1'b0, 1'b1, addr, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cnn_push(input logic [15:0] d);
        res_valid = 1'b1;
        res_data  = d;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    // Monitor: compares every read and every weight handshake against the queues
    rd_exp_t mon_e;
    logic [15:0] mon_w;
    always @(negedge clk) begin
        if (rst_n) begin
            check("wt_valid", 16'(wt_valid), 16'(m_wt_q.size() > 0));
            check("res_ready", 16'(res_ready), 16'(m_res_q.size() < RD));
            check("cnn_start", 16'(cnn_start), 16'(m_start));
            if (!wt_valid) check("wt_data_idle", wt_data, 16'h0000);
            if (mem_en && rd_en) begin
                if (rd_exp_q.size() == 0) fail_event("read with no expectation queued");
                else begin
                    mon_e = rd_exp_q.pop_front();
                    check($sformatf("rd_data@%04h", mon_e.addr), rd_data_mem, mon_e.exp);
                end
            end
            if (wt_valid && wt_ready) begin
                if (wt_exp_q.size() == 0) fail_event("unexpected weight handshake");
                else begin
                    mon_w = wt_exp_q.pop_front();
                    check("wt_data", wt_data, mon_w);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] flag15;
    int          op;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnn_start", 16'(cnn_start), 16'h0);
        check("rst_wt_valid", 16'(wt_valid), 16'h0);
        check("rst_res_ready", 16'(res_ready), 16'h1);
        rst_n = 1'b1;
        idle(1);
        check("post_rst_res_ready", 16'(res_ready), 16'h1);
        check("post_rst_wt_valid", 16'(wt_valid), 16'h0);
        rd_const(16'h0001, 16'h0018);
        rd_const(16'h0004, 16'h0000);

        // Scratch, CTRL read-as-zero, unmapped
        wr(16'h0004, 16'hA5C3);
        rd_const(16'h0004, 16'hA5C3);
        rd_const(16'h0050, 16'h0000);
        rd_const(16'h0000, 16'h0000);

        // Weight overflow then drain in order
        wt_ready = 1'b0;
        for (int i = 0; i < 18; i++) wr(16'h0200 + 16'(i), 16'h1000 + 16'(i));
        rd_const(16'h0002, 16'd16);
        rd_const(16'h0001, 16'h0034);
        wt_ready = 1'b1;
        idle(18);
        check("wt_drained_valid", 16'(wt_valid), 16'h0);
        check("wt_drained_queue", 16'(wt_exp_q.size()), 16'h0);
        wr(16'h0000, 16'h0002);

        // Result FIFO and underflow
        cnn_push(16'h0011);
        cnn_push(16'h0022);
        cnn_push(16'h0033);
        rd_const(16'h0100, 16'h0011);
        rd_const(16'h0101, 16'h0022);
        rd_const(16'h0102, 16'h0033);
        rd_const(16'h0103, 16'h0000);
        rd_const(16'h0001, 16'h0058);
        rd_const(16'h0003, 16'h0000);
        wr(16'h0000, 16'h0002);

        // Start pulse, busy suppression, sticky done
        wr(16'h0000, 16'h0001);
        check("start_pulse", 16'(cnn_start), 16'h1);
        idle(1);
        check("start_one_cycle", 16'(cnn_start), 16'h0);
        cnn_busy = 1'b1;
        wr(16'h0000, 16'h0001);
        check("start_when_busy", 16'(cnn_start), 16'h0);
        cnn_busy = 1'b0;
        cnn_done = 1'b1;
        idle(1);
        cnn_done = 1'b0;
        rd_const(16'h0001, 16'h001A);
        cnn_done = 1'b1;
        wr(16'h0000, 16'h0002);
        cnn_done = 1'b0;
        rd_const(16'h0001, 16'h001A);
        wr(16'h0000, 16'h0002);
        rd_const(16'h0001, 16'h0018);

        // Flush with a concurrent CNN push
        wt_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(16'h0200 + 16'(i), 16'h2000 + 16'(i));
        cnn_push(16'h00A1);
        cnn_push(16'h00A2);
        cnn_push(16'h00A3);
        rd_const(16'h0002, 16'd5);
        rd_const(16'h0003, 16'd3);
        res_valid = 1'b1;
        res_data  = 16'h0077;
        wr(16'h0000, 16'h0004);
        res_valid = 1'b0;
        check("flush_wt_valid", 16'(wt_valid), 16'h0);
        rd_const(16'h0002, 16'h0000);
        rd_const(16'h0003, 16'h0000);
        rd_const(16'h0004, 16'hA5C3);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            wt_ready  = ($urandom_range(0, 3) != 0);
            res_valid = ($urandom_range(0, 2) == 0);
            res_data  = 16'($urandom);
            cnn_busy  = ($urandom_range(0, 3) == 0);
            cnn_done  = ($urandom_range(0, 15) == 0);
            flag15    = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
            op        = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: wr(flag15 | 16'h0200 | 16'($urandom_range(0, 255)), 16'($urandom));
                3, 4:    rd_mdl(flag15 | 16'h0100 | 16'($urandom_range(0, 255)));
                5:       rd_mdl(flag15 | 16'($urandom_range(0, 5)));
                6:       wr(16'h0004, 16'($urandom));
                7:       wr(16'h0000, {13'd0, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3))});
                8:       rd_mdl(flag15 | 16'($urandom_range(16'h0300, 16'h7FFF)));
                default: idle(1);
            endcase
        end
        cnn_busy  = 1'b0;
        cnn_done  = 1'b0;
        res_valid = 1'b0;
        wt_ready  = 1'b1;
        idle(20);
        check("rand_wt_drained", 16'(wt_exp_q.size()), 16'h0);
        check("rand_rd_queue_empty", 16'(rd_exp_q.size()), 16'h0);

        // Asynchronous reset in the middle of a burst
        wr(16'h0004, 16'h1234);
        wt_ready  = 1'b0;
        res_valid = 1'b1;
        res_data  = 16'h0055;
        wr(16'h0000, 16'h0001);
        wr(16'h0200, 16'h3000);
        wr(16'h0201, 16'h3001);
        mem_en   = 1'b1;
        rd_en    = 1'b1;
        addr_mem = 16'h0001;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnn_start", 16'(cnn_start), 16'h0);
        check("mid_rst_wt_valid", 16'(wt_valid), 16'h0);
        check("mid_rst_wt_data", wt_data, 16'h0000);
        check("mid_rst_res_ready", 16'(res_ready), 16'h1);
        check("mid_rst_rd_data", rd_data_mem, 16'h0000);
        mem_en    = 1'b0;
        rd_en     = 1'b0;
        res_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        rd_const(16'h0004, 16'h0000);
        rd_const(16'h0001, 16'h0018);
        rd_const(16'h0002, 16'h0000);
        rd_const(16'h0003, 16'h0000);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
